// File: rtl/spi_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rx_fifo
//  Purpose  : Receive-side byte buffer downstream of spi_master. Every byte
//             flagged by a new_data pulse is pushed into a small synchronous
//             FIFO. The FIFO drains through a registered read port and flags
//             dropped bytes with a sticky overflow bit.
//  Option   : Define SPI_RX_FIFO_FRAME_TAG_EN to tag the first byte written
//             after each falling edge of the active-low chip select (ss).
//             The tag is returned on rd_sof together with the byte.
//  Ports    :
//     clk       in   system clock (CLK_26 domain shared with spi_master)
//     rst       in   asynchronous active-high reset
//     new_data  in   one-cycle pulse, data_in valid in the same cycle
//     data_in   in   [7:0] received byte
//     ss        in   active-low chip select, used only for frame tagging
//     rd_en     in   read request
//     clr_ovf   in   clears the sticky overflow flag
//     rd_data   out  [7:0] registered read byte
//     rd_valid  out  one-cycle pulse per accepted read
//     rd_sof    out  first-byte-of-frame tag, valid with rd_valid
//     empty     out  FIFO holds no entries
//     full      out  FIFO holds DEPTH entries
//     count     out  [AW:0] number of entries
//     overflow  out  sticky, a byte was dropped
//  Revision : 1.0  initial release
// ============================================================================
module spi_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          new_data,
    input  logic [7:0]    data_in,
    input  logic          ss,
    input  logic          rd_en,
    input  logic          clr_ovf,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          rd_sof,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow
);

`ifdef SPI_RX_FIFO_FRAME_TAG_EN
    localparam int c_EW = 9;
`else
    localparam int c_EW = 8;
`endif

    localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------------
    logic [c_EW-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;

    logic            w_rd_acc;
    logic            w_wr_acc;
    logic            w_drop;
    logic [AW:0]     w_count_nxt;
    logic [c_EW-1:0] w_wr_entry;

    // A read needs data present. A write needs a free slot, but when full
    // a read accepted in the same cycle frees the slot being written, since
    // wptr == rptr and the old entry is fetched before it is overwritten.
    // When empty the read is refused, so a concurrent write never falls
    // through to the read port.
    assign w_rd_acc = rd_en && !empty;
    assign w_wr_acc = new_data && (!full || w_rd_acc);
    assign w_drop   = new_data && full && !w_rd_acc;

    always_comb begin
        w_count_nxt = count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = count + 1'b1;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = count - 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Optional frame tagging
    // ------------------------------------------------------------------------
`ifdef SPI_RX_FIFO_FRAME_TAG_EN
    logic r_ss_q;
    logic r_sof_pending;
    logic w_ss_fall;

    assign w_ss_fall  = r_ss_q && !ss;
    assign w_wr_entry = {r_sof_pending, data_in};

    // The chip-select history starts idle (high). A new falling edge arms
    // the flag even if a write lands in the same cycle; only a write that
    // is actually stored consumes it, so dropped bytes leave it armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ss_q        <= 1'b1;
            r_sof_pending <= 1'b0;
        end else begin
            r_ss_q <= ss;
            if (w_ss_fall) begin
                r_sof_pending <= 1'b1;
            end else if (w_wr_acc) begin
                r_sof_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sof <= 1'b0;
        end else if (w_rd_acc) begin
            rd_sof <= r_mem[r_rptr][8];
        end
    end
`else
    logic w_unused_ss;

    assign w_unused_ss = ss;
    assign w_wr_entry  = data_in;
    assign rd_sof      = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Memory array: no reset, contents are don't-care until written
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= w_wr_entry;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, occupancy, status flags and read port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr  <= r_rptr + 1'b1;
                rd_data <= r_mem[r_rptr][7:0];
            end
            rd_valid <= w_rd_acc;
            count    <= w_count_nxt;
            empty    <= (w_count_nxt == '0);
            full     <= (w_count_nxt == c_FULL_CNT);
            // A fresh drop outranks a clear request in the same cycle.
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_rx_fifo
//  Purpose  : Self-checking bench for spi_rx_fifo. A table of single-cycle
//             vectors covers basic reads/writes and the empty corner, and
//             hand-written sequences cover fill/drain, overflow, full with
//             simultaneous read/write, and reset mid-stream with tagging.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst;
    logic          new_data;
    logic [7:0]    data_in;
    logic          ss;
    logic          rd_en;
    logic          clr_ovf;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_sof;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;

    int checks;
    int errors;

    spi_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .new_data (new_data),
        .data_in  (data_in),
        .ss       (ss),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_sof   (rd_sof),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       nd;
        logic [7:0] din;
        logic       re;
        logic       co;
        logic       e_valid;
        logic [7:0] e_data;
        int         e_count;
        logic       e_empty;
        logic       e_full;
        logic       e_ovf;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs, then sample 1 ns after the rising edge.
    task automatic step(input logic nd, input logic [7:0] d, input logic re, input logic co);
        new_data = nd;
        data_in  = d;
        rd_en    = re;
        clr_ovf  = co;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, base + 8'(i), 1'b0, 1'b0);
        end
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        idle();
    endtask

    vec_t vecs [11];

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        new_data = 1'b0;
        data_in  = 8'h00;
        ss       = 1'b1;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;

        //            nd   din    re   co   valid data  cnt empty full ovf
        vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h3C, 1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h3C, 2, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h11, 2, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h33, 0, 1'b1, 1'b0, 1'b0};

        // ---------------- reset values ----------------
        idle();
        idle();
        check("reset rd_data",  rd_data,  8'h00);
        check("reset rd_valid", rd_valid, 0);
        check("reset rd_sof",   rd_sof,   0);
        check("reset empty",    empty,    1);
        check("reset full",     full,     0);
        check("reset count",    count,    0);
        check("reset overflow", overflow, 0);
        rst = 1'b0;
        idle();

        // ---------------- table vectors ----------------
        for (int v = 0; v < 11; v++) begin
            step(vecs[v].nd, vecs[v].din, vecs[v].re, vecs[v].co);
            check($sformatf("vec%0d rd_valid", v), rd_valid, vecs[v].e_valid);
            check($sformatf("vec%0d rd_data", v),  rd_data,  vecs[v].e_data);
            check($sformatf("vec%0d count", v),    count,    vecs[v].e_count);
            check($sformatf("vec%0d empty", v),    empty,    vecs[v].e_empty);
            check($sformatf("vec%0d full", v),     full,     vecs[v].e_full);
            check($sformatf("vec%0d overflow", v), overflow, vecs[v].e_ovf);
            if (vecs[v].e_valid) begin
                check($sformatf("vec%0d rd_sof", v), rd_sof, 0);
            end
        end
        idle();

        // ---------------- fill and drain ----------------
        do_reset();
        fill(8'hA0);
        check("fill full",  full,  1);
        check("fill count", count, 16);
        check("fill empty", empty, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("drain%0d rd_valid", i), rd_valid, 1);
            check($sformatf("drain%0d rd_data", i),  rd_data,  8'hA0 + i);
        end
        idle();
        check("drained rd_valid", rd_valid, 0);
        check("drained empty",    empty,    1);
        check("drained count",    count,    0);
        check("drained full",     full,     0);

        // ---------------- overflow ----------------
        fill(8'h00);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        check("ovf set",   overflow, 1);
        check("ovf count", count,    16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf clear", overflow, 0);
        step(1'b1, 8'h66, 1'b0, 1'b1);
        check("ovf set beats clear", overflow, 1);
        check("ovf count2",          count,    16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf clear2", overflow, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("ovf drain%0d", i), rd_data, i);
        end
        idle();
        check("ovf drained empty", empty, 1);

        // ---------------- full with simultaneous read/write ----------------
        fill(8'h80);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("fullrw rd_valid", rd_valid, 1);
        check("fullrw rd_data",  rd_data,  8'h80);
        check("fullrw count",    count,    16);
        check("fullrw full",     full,     1);
        check("fullrw overflow", overflow, 0);
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("fullrw drain%0d", i), rd_data, 8'h80 + i);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("fullrw last", rd_data, 8'h77);
        idle();
        check("fullrw empty", empty, 1);

        // ---------------- reset mid-stream, frame tag ----------------
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
        end
        rd_en = 1'b1;
        rst   = 1'b1;
        #1;
        check("async rst count", count, 0);
        idle();
        rst = 1'b0;
        check("midrst empty",    empty,    1);
        check("midrst count",    count,    0);
        check("midrst rd_valid", rd_valid, 0);
        ss = 1'b0;
        idle();
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        idle();
        check("tag count", count, 2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("tag rd0 data", rd_data, 8'h01);
`ifdef SPI_RX_FIFO_FRAME_TAG_EN
        check("tag rd0 sof", rd_sof, 1);
`else
        check("tag rd0 sof", rd_sof, 0);
`endif
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("tag rd1 data", rd_data, 8'h02);
        check("tag rd1 sof",  rd_sof,  0);
        ss = 1'b1;
        idle();
        check("tag end empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
